serial_word_rx: RTL and testbench
=================================

# serial_word_rx

Serial-to-parallel frame receiver: the receiving end of the team's 4-bit serial shift link. It samples a serial bit stream qualified by a bit strobe and detects a start bit. It assembles W data bits in MSB-first or LSB-first order, checks an even-parity bit, and presents the word on a held parallel output with a valid/acknowledge handshake.

## Interface
- W, default 4, data bits per frame (2..16)
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-high reset
- sin  in  1  serial data bit
- sval  in  1  sin qualifier; a bit is consumed only on a clk edge with sval=1
- dir  in  1  bit order: 0 = MSB first (left shift), 1 = LSB first (right shift); sampled with the start bit
- ack  in  1  consumer acknowledges the held word
- dout  out  W  received word
- dvalid  out  1  dout holds an unacknowledged word
- perr  out  1  one-cycle pulse: parity error, frame discarded
- ovr  out  1  one-cycle pulse: new word overwrote an unacknowledged word
- busy  out  1  high while in DATA or PAR

## Operation
- Frame, one bit per strobed cycle: start bit (sin=1), W data bits, parity bit with XOR(data, parity) = 0 (even parity).
- FSM states:
  - IDLE: sval=1 and sin=1 → DATA; latch dir, clear the shift register and bit counter. sval=1 and sin=0 is ignored.
  - DATA: each strobed bit shifts in.
    - dir=0: sr <= {sr[W-2:0], sin}.
    - dir=1: sr <= {sin, sr[W-1:1]}.
    - Counter increments; after the W-th bit → PAR.
  - PAR: strobed bit is compared with the running XOR of the data bits → IDLE.
    - Parity good: dout <= sr, dvalid <= 1.
    - Parity bad: perr pulses; dout and dvalid are unchanged.
- sval=0 in any state stalls the FSM; no timeout.
- dvalid clears on the clk edge where ack=1 and dvalid=1. ack while dvalid=0 is ignored.
- A good frame completes while dvalid=1 and ack=0: dout is overwritten, dvalid stays 1, ovr pulses.
- A good frame completes while dvalid=1 and ack=1 in the same cycle: the new word loads, dvalid stays 1, no ovr.
- A start bit is accepted in the same cycle dvalid sets.
- dir changes mid-frame have no effect.

## Timing
- Reset values: dout=0, dvalid=0, perr=0, ovr=0, busy=0, FSM=IDLE, counter=0, shift register=0.
- clr asserted mid-frame aborts the frame immediately (asynchronously). Nothing is reported.
- Minimum frame: W+2 consecutive strobed cycles.
- dout, dvalid, perr and ovr are all registered. They update on the same edge that samples the parity bit, i.e. visible 1 cycle after the parity bit is presented.
- busy is high from the edge after the start bit through the edge that samples parity.
- Back-to-back frames are supported: a start bit may follow on the cycle immediately after the parity bit.

## Structure
- Shared package shift_pkg:
  - FSM state encoding (IDLE, DATA, PAR).
  - dir constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1.
  - Start-bit constant START_BIT=1.
- One sub-module, rx_shreg: W-bit directional shift register with clear, shift-enable, dir, serial-in, and running XOR parity output.
- Control FSM, counter and handshake logic live in serial_word_rx.

## Test plan (W=4)
- MSB first, dir=0: strobe 1,1,0,1,1,1 → dout=4'b1011, dvalid=1 one cycle after the last bit; perr=0.
- LSB first, dir=1: strobe 1,1,1,0,1,1 → dout=4'b1011, dvalid=1.
- Parity error: strobe 1,1,0,1,1,0 → perr pulses for 1 cycle; dvalid=0; dout keeps its previous value.
- Overrun: two good frames, 4'b1011 then 4'b0110 (strobe 1,0,1,1,0,0), with ack=0 throughout → ovr pulses once; dout=4'b0110; dvalid=1. Repeat with ack=1 on the completion cycle → no ovr.
- Stalls and reset:
  - Insert sval=0 gaps between every bit of frame 4'b1011 → same result as the gap-free frame.
  - Assert clr after the 2nd data bit → all outputs 0 immediately; the next clean frame 4'b0001 (strobe 1,0,0,0,1,1) receives correctly.
- Idle noise: sval=1 with sin=0 for 10 cycles → busy stays 0; no outputs change.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the 4-bit serial shift link: FSM encoding, bit-order
// and framing constants.
package shift_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StData = 2'd1,
    StPar  = 2'd2
  } rx_state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;
  localparam logic START_BIT     = 1'b1;

  // Counter width able to index W data bits (W >= 2).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_word_rx_if.sv
// Serial input, handshake and status signals of serial_word_rx.
// master = link driver / word consumer, slave = the receiver.
interface serial_word_rx_if #(
  parameter int unsigned W = 4
);
  logic         sin;
  logic         sval;
  logic         dir;
  logic         ack;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         perr;
  logic         ovr;
  logic         busy;

  modport master (
    output sin, sval, dir, ack,
    input  dout, dvalid, perr, ovr, busy
  );

  modport slave (
    input  sin, sval, dir, ack,
    output dout, dvalid, perr, ovr, busy
  );
endinterface

// File: rtl/rx_shreg.sv
// W-bit directional shift register with synchronous clear and a running
// XOR of every bit shifted in since the last clear.
module rx_shreg
  import shift_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         init,
  input  logic         en,
  input  logic         dir,
  input  logic         sin,
  output logic [W-1:0] sr,
  output logic         par
);

  logic [W-1:0] sr_q;
  logic         par_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else if (init) begin
      sr_q  <= '0;
      par_q <= 1'b0;
    end else if (en) begin
      if (dir == DIR_LSB_FIRST) begin
        sr_q <= {sin, sr_q[W-1:1]};
      end else begin
        sr_q <= {sr_q[W-2:0], sin};
      end
      par_q <= par_q ^ sin;
    end
  end

  assign sr  = sr_q;
  assign par = par_q;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel frame receiver: start bit, W data bits, even parity bit,
// with the word held on dout under a valid/acknowledge handshake.
module serial_word_rx
  import shift_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic            clk,
  input  logic            clr,
  serial_word_rx_if.slave bus
);

  localparam int unsigned CntW = cnt_width(W);

  rx_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          dvalid_q, dvalid_d;
  logic          perr_q, perr_d;
  logic          ovr_q, ovr_d;

  logic          sr_init;
  logic          sr_en;
  logic [W-1:0]  sr;
  logic          sr_par;

  rx_shreg #(
    .W (W)
  ) u_shreg (
    .clk  (clk),
    .clr  (clr),
    .init (sr_init),
    .en   (sr_en),
    .dir  (dir_q),
    .sin  (bus.sin),
    .sr   (sr),
    .par  (sr_par)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      dir_q    <= DIR_MSB_FIRST;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    perr_d   = 1'b0;
    ovr_d    = 1'b0;
    sr_init  = 1'b0;
    sr_en    = 1'b0;

    if (bus.ack && dvalid_q) begin
      dvalid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.sval && (bus.sin == START_BIT)) begin
          state_d = StData;
          dir_d   = bus.dir;
          cnt_d   = '0;
          sr_init = 1'b1;
        end
      end
      StData: begin
        if (bus.sval) begin
          sr_en = 1'b1;
          if (cnt_q == CntW'(W - 1)) begin
            state_d = StPar;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPar: begin
        if (bus.sval) begin
          state_d = StIdle;
          if (sr_par ^ bus.sin) begin
            perr_d = 1'b1;
          end else begin
            dout_d   = sr;
            dvalid_d = 1'b1;
            // A same-cycle ack retires the old word, so nothing is lost.
            ovr_d    = dvalid_q && !bus.ack;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;
  assign bus.perr   = perr_q;
  assign bus.ovr    = ovr_q;
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (W=4): each task drives one scenario and
// checks outputs 1 time unit after the sampling clock edge.
module tb_serial_word_rx;

  logic clk;
  logic clr;
  int   checks;
  int   passed;

  serial_word_rx_if #(.W(4)) sif ();

  serial_word_rx #(
    .W (4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic strobe(input logic b);
    sif.sin  = b;
    sif.sval = 1'b1;
    @(posedge clk);
    #1;
    sif.sval = 1'b0;
    sif.sin  = 1'b0;
  endtask

  task automatic send(input logic [5:0] f);
    for (int i = 5; i >= 0; i--) strobe(f[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_ack();
    sif.ack = 1'b1;
    @(posedge clk);
    #1;
    sif.ack = 1'b0;
    checks++;
    if (sif.dvalid !== 1'b0) $display("FAIL ack_clear dvalid got %b want 0", sif.dvalid);
    else passed++;
  endtask

  task automatic test_reset();
    clr      = 1'b1;
    sif.sin  = 1'b0;
    sif.sval = 1'b0;
    sif.dir  = 1'b0;
    sif.ack  = 1'b0;
    #12;
    checks++;
    if (sif.dout !== 4'b0000) $display("FAIL reset_dout got %b want 0000", sif.dout);
    else passed++;
    checks++;
    if (sif.dvalid !== 1'b0) $display("FAIL reset_dvalid got %b want 0", sif.dvalid);
    else passed++;
    checks++;
    if (sif.perr !== 1'b0 || sif.ovr !== 1'b0) $display("FAIL reset_pulses got perr=%b ovr=%b want 0 0", sif.perr, sif.ovr);
    else passed++;
    checks++;
    if (sif.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", sif.busy);
    else passed++;
    clr = 1'b0;
    idle(1);
  endtask

  task automatic test_msb_first();
    sif.dir = 1'b0;
    strobe(1'b1);
    checks++;
    if (sif.busy !== 1'b1) $display("FAIL msb_busy_after_start got %b want 1", sif.busy);
    else passed++;
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    checks++;
    if (sif.dvalid !== 1'b0) $display("FAIL msb_dvalid_before_parity got %b want 0", sif.dvalid);
    else passed++;
    strobe(1'b1);
    checks++;
    if (sif.dout !== 4'b1011) $display("FAIL msb_dout got %b want 1011", sif.dout);
    else passed++;
    checks++;
    if (sif.dvalid !== 1'b1 || sif.perr !== 1'b0 || sif.ovr !== 1'b0)
      $display("FAIL msb_flags got dvalid=%b perr=%b ovr=%b want 1 0 0", sif.dvalid, sif.perr, sif.ovr);
    else passed++;
    checks++;
    if (sif.busy !== 1'b0) $display("FAIL msb_busy_after_parity got %b want 0", sif.busy);
    else passed++;
    do_ack();
  endtask

  task automatic test_parity_error();
    send(6'b110110);
    checks++;
    if (sif.perr !== 1'b1) $display("FAIL perr_pulse got %b want 1", sif.perr);
    else passed++;
    checks++;
    if (sif.dvalid !== 1'b0 || sif.dout !== 4'b1011)
      $display("FAIL perr_hold got dvalid=%b dout=%b want 0 1011", sif.dvalid, sif.dout);
    else passed++;
    idle(1);
    checks++;
    if (sif.perr !== 1'b0) $display("FAIL perr_one_cycle got %b want 0", sif.perr);
    else passed++;
  endtask

  task automatic test_clr_mid_frame();
    strobe(1'b1); strobe(1'b1); strobe(1'b0);
    clr = 1'b1;
    #1;
    checks++;
    if (sif.dout !== 4'b0000 || sif.dvalid !== 1'b0 || sif.busy !== 1'b0)
      $display("FAIL clr_async got dout=%b dvalid=%b busy=%b want 0000 0 0", sif.dout, sif.dvalid, sif.busy);
    else passed++;
    @(posedge clk);
    #1;
    clr = 1'b0;
    send(6'b100011);
    checks++;
    if (sif.dout !== 4'b0001 || sif.dvalid !== 1'b1 || sif.perr !== 1'b0)
      $display("FAIL clr_next_frame got dout=%b dvalid=%b perr=%b want 0001 1 0", sif.dout, sif.dvalid, sif.perr);
    else passed++;
    do_ack();
  endtask

  task automatic test_lsb_first();
    sif.dir = 1'b1;
    strobe(1'b1);
    sif.dir = 1'b0;  // must not affect the frame in flight
    strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    checks++;
    if (sif.dout !== 4'b1011 || sif.dvalid !== 1'b1)
      $display("FAIL lsb_word got dout=%b dvalid=%b want 1011 1", sif.dout, sif.dvalid);
    else passed++;
    do_ack();
  endtask

  task automatic test_overrun();
    sif.dir = 1'b0;
    send(6'b110111);
    checks++;
    if (sif.dvalid !== 1'b1 || sif.ovr !== 1'b0)
      $display("FAIL ovr_first got dvalid=%b ovr=%b want 1 0", sif.dvalid, sif.ovr);
    else passed++;
    send(6'b101100);
    checks++;
    if (sif.ovr !== 1'b1) $display("FAIL ovr_pulse got %b want 1", sif.ovr);
    else passed++;
    checks++;
    if (sif.dout !== 4'b0110 || sif.dvalid !== 1'b1)
      $display("FAIL ovr_word got dout=%b dvalid=%b want 0110 1", sif.dout, sif.dvalid);
    else passed++;
    strobe(1'b1); strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    checks++;
    if (sif.ovr !== 1'b0) $display("FAIL ovr_one_cycle got %b want 0", sif.ovr);
    else passed++;
    sif.ack = 1'b1;
    strobe(1'b1);
    sif.ack = 1'b0;
    checks++;
    if (sif.ovr !== 1'b0 || sif.dvalid !== 1'b1 || sif.dout !== 4'b1011)
      $display("FAIL ovr_ack_same_cycle got ovr=%b dvalid=%b dout=%b want 0 1 1011", sif.ovr, sif.dvalid, sif.dout);
    else passed++;
    do_ack();
  endtask

  task automatic test_stall();
    logic [5:0] f;
    send(6'b101100);
    do_ack();
    f = 6'b110111;
    for (int i = 5; i >= 0; i--) begin
      strobe(f[i]);
      if (i > 0) begin
        sif.sin = 1'b1;  // noise on sin while unqualified
        idle(2);
        checks++;
        if (sif.busy !== 1'b1) $display("FAIL stall_busy bit %0d got %b want 1", i, sif.busy);
        else passed++;
        sif.sin = 1'b0;
      end
    end
    checks++;
    if (sif.dout !== 4'b1011 || sif.dvalid !== 1'b1 || sif.busy !== 1'b0)
      $display("FAIL stall_word got dout=%b dvalid=%b busy=%b want 1011 1 0", sif.dout, sif.dvalid, sif.busy);
    else passed++;
  endtask

  task automatic test_idle_noise();
    sif.sval = 1'b1;
    sif.sin  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sif.busy !== 1'b0) $display("FAIL noise_busy cycle %0d got %b want 0", i, sif.busy);
      else passed++;
    end
    sif.sval = 1'b0;
    checks++;
    if (sif.dout !== 4'b1011 || sif.dvalid !== 1'b1 || sif.perr !== 1'b0 || sif.ovr !== 1'b0)
      $display("FAIL noise_outputs got dout=%b dvalid=%b perr=%b ovr=%b want 1011 1 0 0",
               sif.dout, sif.dvalid, sif.perr, sif.ovr);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_msb_first();
    test_parity_error();
    test_clr_mid_frame();
    test_lsb_first();
    test_overrun();
    test_stall();
    test_idle_noise();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
